// File: rtl/mem_port_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared state encodings, owner IDs and counter width for the
//            unified memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM: idle (grant possible) or waiting for read data
  typedef enum logic [0:0] {
    S_ARB_IDLE    = 1'b0,
    S_ARB_RD_WAIT = 1'b1
  } arb_state_t;

  // Requester identifiers, also used as the last_owner / owner encoding
  localparam logic ARB_OWNER_M0 = 1'b0;
  localparam logic ARB_OWNER_M1 = 1'b1;

  // Width of the read-latency down-counter (RD_LAT-1 never exceeds 3)
  localparam int ARB_RD_CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Combinational two-way winner select. Single requester wins
//            outright; on a tie either M0 (fixed priority) or the master that
//            did not win last time (round robin). Holds no state.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_owner,
  output logic o_valid,
  output logic o_winner
);

  // Winner select: ties resolved by priority mode, otherwise the lone requester
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = ARB_OWNER_M0;
    if (i_req0 && i_req1) begin
      o_winner = (FIXED_PRIO != 0) ? ARB_OWNER_M0 : ~i_last_owner;
    end else if (i_req1) begin
      o_winner = ARB_OWNER_M1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one non-pipelined unified memory port between the CPU
//            port (M0) and a loader/DMA port (M1). Writes complete in the
//            grant cycle; reads hold the port for RD_LAT cycles and the read
//            data is passed straight through to the owning master.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N          = 32,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         m0_req,
  input  logic         m0_we,
  input  logic [N-1:0] m0_addr,
  input  logic [N-1:0] m0_wdata,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic [N-1:0] m0_rdata,
  input  logic         m1_req,
  input  logic         m1_we,
  input  logic [N-1:0] m1_addr,
  input  logic [N-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic [N-1:0] m1_rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  output logic         mem_wr_ena,
  input  logic [N-1:0] mem_rd_data,
  output logic [31:0]  conflict_count
);

  localparam logic [ARB_RD_CNT_W-1:0] c_RD_CNT_INIT = ARB_RD_CNT_W'(RD_LAT - 1);

  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT=%0d outside legal range 1..4", RD_LAT);
  end

  arb_state_t                r_state;
  arb_state_t                w_next_state;
  logic [ARB_RD_CNT_W-1:0]   r_rd_cnt;
  logic                      r_owner;
  logic                      r_last_owner;
  logic [N-1:0]              r_rd_addr;
  logic [31:0]               r_conflict_count;

  logic                      w_req_any;
  logic                      w_winner;
  logic                      w_grant;
  logic                      w_win_we;
  logic [N-1:0]              w_win_addr;
  logic [N-1:0]              w_win_wdata;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr_arbiter2 (
    .i_req0       (m0_req),
    .i_req1       (m1_req),
    .i_last_owner (r_last_owner),
    .o_valid      (w_req_any),
    .o_winner     (w_winner)
  );

  assign w_win_we    = (w_winner == ARB_OWNER_M1) ? m1_we    : m0_we;
  assign w_win_addr  = (w_winner == ARB_OWNER_M1) ? m1_addr  : m0_addr;
  assign w_win_wdata = (w_winner == ARB_OWNER_M1) ? m1_wdata : m0_wdata;
  assign conflict_count = r_conflict_count;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_ARB_IDLE;
    else      r_state <= w_next_state;
  end

  // Next state and port outputs; everything is forced quiet while reset is low
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    mem_wr_ena   = 1'b0;
    if (rst) begin
      case (r_state)
        S_ARB_IDLE: begin
          if (w_req_any) begin
            w_grant     = 1'b1;
            m0_gnt      = (w_winner == ARB_OWNER_M0);
            m1_gnt      = (w_winner == ARB_OWNER_M1);
            mem_addr    = w_win_addr;
            mem_wr_data = w_win_wdata;
            mem_wr_ena  = w_win_we;
            if (!w_win_we) w_next_state = S_ARB_RD_WAIT;
          end
        end
        S_ARB_RD_WAIT: begin
          mem_addr = r_rd_addr;
          if (r_rd_cnt == '0) begin
            w_next_state = S_ARB_IDLE;
            if (r_owner == ARB_OWNER_M0) begin
              m0_rvalid = 1'b1;
              m0_rdata  = mem_rd_data;
            end else begin
              m1_rvalid = 1'b1;
              m1_rdata  = mem_rd_data;
            end
          end
        end
        default: w_next_state = S_ARB_IDLE;
      endcase
    end
  end

  // Ownership, held read address and read-latency countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt     <= '0;
      r_owner      <= ARB_OWNER_M0;
      r_last_owner <= ARB_OWNER_M1;
      r_rd_addr    <= '0;
    end else if (w_grant) begin
      r_owner      <= w_winner;
      r_last_owner <= w_winner;
      if (!w_win_we) begin
        r_rd_cnt  <= c_RD_CNT_INIT;
        r_rd_addr <= w_win_addr;
      end
    end else if ((r_state == S_ARB_RD_WAIT) && (r_rd_cnt != '0)) begin
      r_rd_cnt <= r_rd_cnt - 1'b1;
    end
  end

  // Count idle cycles in which both masters contend; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict_count <= '0;
    end else if ((r_state == S_ARB_IDLE) && m0_req && m1_req) begin
      r_conflict_count <= r_conflict_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench. Three arbiter instances share one
//            stimulus: [0] RD_LAT=1 round robin, [1] RD_LAT=3 round robin,
//            [2] RD_LAT=2 fixed priority. A small word memory serves the
//            instance selected by mem_sel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] mem_rd_data;
  logic [1:0]  mem_sel;

  logic [2:0]  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wr_ena;
  logic [31:0] m0_rdata [3];
  logic [31:0] m1_rdata [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wr_data [3];
  logic [31:0] conflict_count [3];
  logic [31:0] mem [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    localparam int FP  = (g == 2) ? 1 : 0;
    mem_port_arbiter #(.N(32), .RD_LAT(LAT), .FIXED_PRIO(FP)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wr_data(mem_wr_data[g]), .mem_wr_ena(mem_wr_ena[g]),
      .mem_rd_data(mem_rd_data), .conflict_count(conflict_count[g])
    );
  end

  // Word memory: combinational read at the selected instance's address, preloaded on reset
  assign mem_rd_data = mem[mem_addr[mem_sel][5:2]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_wr_ena[mem_sel]) begin
      mem[mem_addr[mem_sel][5:2]] <= mem_wr_data[mem_sel];
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b0; m0_addr = 32'h8; m1_addr = 32'hC;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 6'b0) begin failures++; $display("FAIL reset_gnt: got %b required 0", {m0_gnt, m1_gnt}); end
    checks++; if ({m0_rvalid, m1_rvalid, mem_wr_ena} !== 9'b0) begin failures++; $display("FAIL reset_valid_wena: got %b required 0", {m0_rvalid, m1_rvalid, mem_wr_ena}); end
    checks++; if (mem_addr[0] !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr[0]); end
    @(negedge clk);
    #1;
    checks++; if (conflict_count[0] !== 32'h0) begin failures++; $display("FAIL reset_conflict: got %h required 0", conflict_count[0]); end
    reset_all();
  endtask

  task automatic test_single_write_read();
    mem_sel = 2'd0;
    reset_all();
    drive(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checks++; if (m0_gnt[0] !== 1'b1) begin failures++; $display("FAIL t1_wr_gnt: got %b required 1", m0_gnt[0]); end
    checks++; if (mem_wr_ena[0] !== 1'b1) begin failures++; $display("FAIL t1_wr_ena: got %b required 1", mem_wr_ena[0]); end
    checks++; if (mem_addr[0] !== 32'h10 || mem_wr_data[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t1_wr_bus: got %h/%h required 10/deadbeef", mem_addr[0], mem_wr_data[0]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (mem_wr_ena[0] !== 1'b0 || m0_gnt[0] !== 1'b0) begin failures++; $display("FAIL t1_wr_one_cycle: got wena=%b gnt=%b required 0/0", mem_wr_ena[0], m0_gnt[0]); end
    checks++; if (mem_addr[0] !== 32'h0 || mem_wr_data[0] !== 32'h0) begin failures++; $display("FAIL t1_idle_bus: got %h/%h required 0/0", mem_addr[0], mem_wr_data[0]); end
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    checks++; if (m0_gnt[0] !== 1'b1 || m0_rvalid[0] !== 1'b0 || mem_wr_ena[0] !== 1'b0) begin failures++; $display("FAIL t1_rd_gnt: got gnt=%b rv=%b wena=%b required 1/0/0", m0_gnt[0], m0_rvalid[0], mem_wr_ena[0]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (m0_rvalid[0] !== 1'b1) begin failures++; $display("FAIL t1_rvalid: got %b required 1", m0_rvalid[0]); end
    checks++; if (m0_rdata[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t1_rdata: got %h required deadbeef", m0_rdata[0]); end
    checks++; if (mem_addr[0] !== 32'h10) begin failures++; $display("FAIL t1_rd_addr_hold: got %h required 10", mem_addr[0]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (m0_rvalid[0] !== 1'b0 || m0_rdata[0] !== 32'h0) begin failures++; $display("FAIL t1_rdata_idle: got rv=%b data=%h required 0/0", m0_rvalid[0], m0_rdata[0]); end
  endtask

  task automatic test_tie_reads();
    mem_sel = 2'd2;
    reset_all();
    drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    checks++; if (m0_gnt[2] !== 1'b1 || m1_gnt[2] !== 1'b0) begin failures++; $display("FAIL t2_first_gnt: got m0=%b m1=%b required 1/0", m0_gnt[2], m1_gnt[2]); end
    drive(0, 0, 0, 0, 1, 0, 32'h4, 0);
    checks++; if (m1_gnt[2] !== 1'b0 || m0_rvalid[2] !== 1'b0) begin failures++; $display("FAIL t2_wait: got m1gnt=%b m0rv=%b required 0/0", m1_gnt[2], m0_rvalid[2]); end
    drive(0, 0, 0, 0, 1, 0, 32'h4, 0);
    checks++; if (m0_rvalid[2] !== 1'b1 || m0_rdata[2] !== 32'hA000_0000 || m1_gnt[2] !== 1'b0) begin failures++; $display("FAIL t2_m0_rvalid: got rv=%b data=%h m1gnt=%b required 1/a0000000/0", m0_rvalid[2], m0_rdata[2], m1_gnt[2]); end
    drive(0, 0, 0, 0, 1, 0, 32'h4, 0);
    checks++; if (m1_gnt[2] !== 1'b1 || mem_addr[2] !== 32'h4) begin failures++; $display("FAIL t2_m1_gnt: got gnt=%b addr=%h required 1/4", m1_gnt[2], mem_addr[2]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (m1_rvalid[2] !== 1'b0) begin failures++; $display("FAIL t2_m1_early: got %b required 0", m1_rvalid[2]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (m1_rvalid[2] !== 1'b1 || m1_rdata[2] !== 32'hA000_0001) begin failures++; $display("FAIL t2_m1_rvalid: got rv=%b data=%h required 1/a0000001", m1_rvalid[2], m1_rdata[2]); end
    checks++; if (conflict_count[2] !== 32'd1) begin failures++; $display("FAIL t2_conflict: got %0d required 1", conflict_count[2]); end
  endtask

  task automatic test_back_to_back();
    mem_sel = 2'd0;
    reset_all();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 32'h20, 32'h100 + 32'(i), 1, 1, 32'h24, 32'h200 + 32'(i));
      checks++; if (m0_gnt[0] !== (i % 2 == 0) || m1_gnt[0] !== (i % 2 == 1)) begin failures++; $display("FAIL t3_rr_cycle%0d: got m0=%b m1=%b required %b/%b", i, m0_gnt[0], m1_gnt[0], (i % 2 == 0), (i % 2 == 1)); end
      checks++; if (m0_gnt[2] !== 1'b1 || m1_gnt[2] !== 1'b0) begin failures++; $display("FAIL t3_fixed_cycle%0d: got m0=%b m1=%b required 1/0", i, m0_gnt[2], m1_gnt[2]); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (conflict_count[0] !== 32'd6 || conflict_count[2] !== 32'd6) begin failures++; $display("FAIL t3_conflict: got %0d/%0d required 6/6", conflict_count[0], conflict_count[2]); end
  endtask

  task automatic test_reset_mid_read();
    mem_sel = 2'd1;
    reset_all();
    drive(0, 0, 0, 0, 1, 0, 32'h8, 0);
    checks++; if (m1_gnt[1] !== 1'b1) begin failures++; $display("FAIL t4_m1_gnt: got %b required 1", m1_gnt[1]); end
    @(negedge clk);
    rst = 1'b0; m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b1;
    #1;
    checks++; if (m1_rvalid[1] !== 1'b0 || m0_gnt[1] !== 1'b0 || mem_wr_ena[1] !== 1'b0 || mem_addr[1] !== 32'h0) begin failures++; $display("FAIL t4_outputs_in_reset: got rv=%b gnt=%b wena=%b addr=%h required 0/0/0/0", m1_rvalid[1], m0_gnt[1], mem_wr_ena[1], mem_addr[1]); end
    @(negedge clk);
    rst = 1'b1; m0_req = 1'b0; m0_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (m1_rvalid[1] !== 1'b0) begin failures++; $display("FAIL t4_no_rvalid%0d: got %b required 0", k, m1_rvalid[1]); end
    end
    drive(1, 1, 32'h40, 32'h1, 1, 1, 32'h44, 32'h2);
    checks++; if (m0_gnt[1] !== 1'b1 || m1_gnt[1] !== 1'b0) begin failures++; $display("FAIL t4_tie_after_reset: got m0=%b m1=%b required 1/0", m0_gnt[1], m1_gnt[1]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_all();
    drive(1, 1, 32'h40, 32'h1, 1, 1, 32'h44, 32'h2);
    checks++; if (m0_gnt[1] !== 1'b1 || m1_gnt[1] !== 1'b0) begin failures++; $display("FAIL t4_last_owner_reset: got m0=%b m1=%b required 1/0", m0_gnt[1], m1_gnt[1]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_write_during_read();
    mem_sel = 2'd1;
    reset_all();
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
    checks++; if (m1_gnt[1] !== 1'b1) begin failures++; $display("FAIL t5_rd_gnt: got %b required 1", m1_gnt[1]); end
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, 32'h30, 32'h1234_5678, 0, 0, 0, 0);
      checks++; if (m0_gnt[1] !== 1'b0 || mem_wr_ena[1] !== 1'b0) begin failures++; $display("FAIL t5_blocked%0d: got gnt=%b wena=%b required 0/0", k, m0_gnt[1], mem_wr_ena[1]); end
    end
    checks++; if (m1_rvalid[1] !== 1'b1 || m1_rdata[1] !== 32'hA000_0004) begin failures++; $display("FAIL t5_rvalid: got rv=%b data=%h required 1/a0000004", m1_rvalid[1], m1_rdata[1]); end
    drive(1, 1, 32'h30, 32'h1234_5678, 0, 0, 0, 0);
    checks++; if (m0_gnt[1] !== 1'b1 || mem_wr_ena[1] !== 1'b1 || mem_addr[1] !== 32'h30) begin failures++; $display("FAIL t5_wr_gnt: got gnt=%b wena=%b addr=%h required 1/1/30", m0_gnt[1], mem_wr_ena[1], mem_addr[1]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_conflict_wrap();
    mem_sel = 2'd0;
    reset_all();
    @(negedge clk);
    force g_dut[0].u_dut.r_conflict_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release g_dut[0].u_dut.r_conflict_count;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h28;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h2C;
    #1;
    checks++; if (conflict_count[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL t6_preload: got %h required ffffffff", conflict_count[0]); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (conflict_count[0] !== 32'h0) begin failures++; $display("FAIL t6_wrap: got %h required 0", conflict_count[0]); end
  endtask

  initial begin
    rst = 1'b0; mem_sel = 2'd0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    test_reset();
    test_single_write_read();
    test_tie_reads();
    test_back_to_back();
    test_reset_mid_read();
    test_write_during_read();
    test_conflict_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified (von Neumann) memory port between two requesters: M0, the multicycle CPU data/fetch port, and M1, a loader/DMA port. Uses a per-master req/gnt handshake with round-robin or fixed priority. Non-pipelined: one access in flight at a time. Sits between the CPU top level and the unified instruction/data memory.

Parameters:
N, 32, address/data width
RD_LAT, 1, memory read latency in cycles from the address cycle to valid mem_rd_data; legal range 1..4
FIXED_PRIO, 0, 0 = round-robin on ties; 1 = M0 always wins ties

Ports:
clk  input  1  clock
rst  input  1  reset
m0_req  input  1  M0 access request
m0_we  input  1  M0 write (1) / read (0)
m0_addr  input  N  M0 byte address
m0_wdata  input  N  M0 write data
m0_gnt  output  1  M0 granted this cycle (combinational)
m0_rvalid  output  1  M0 read data valid
m0_rdata  output  N  M0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as M0, for M1
mem_addr  output  N  to memory
mem_wr_data  output  N  to memory
mem_wr_ena  output  1  to memory
mem_rd_data  input  N  from memory
conflict_count  output  32  number of cycles in which both requests were high while in S_IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (while rst=0):
  - state = S_IDLE, rd_cnt = 0, owner = 0
  - last_owner = 1, so M0 wins the first tie
  - conflict_count = 0
  - all gnt/rvalid = 0, mem_wr_ena = 0
- States: S_IDLE, S_RD_WAIT.
- S_IDLE, winner selection:
  - Only one req high: that master wins.
  - Both high: FIXED_PRIO=1 gives M0. FIXED_PRIO=0 gives the master that is not last_owner.
- S_IDLE, outputs and updates on a grant:
  - Winner's gnt = 1 combinationally in the same cycle.
  - mem_addr = winner addr, mem_wr_data = winner wdata, mem_wr_ena = winner we.
  - On the clock edge: last_owner <= winner, owner <= winner.
  - Write: completes in the grant cycle; state stays S_IDLE, so a new grant is possible the next cycle.
  - Read: rd_cnt <= RD_LAT-1, state <= S_RD_WAIT.
- S_RD_WAIT:
  - No grants; all gnt = 0.
  - mem_addr is held at the registered read address; mem_wr_ena = 0.
  - When rd_cnt != 0: decrement rd_cnt.
  - When rd_cnt == 0: owner's rvalid = 1 and owner's rdata = mem_rd_data, passed through the same cycle; state <= S_IDLE.
  - Latency: a read granted at cycle t gives rvalid at t+RD_LAT. The next grant is possible at t+RD_LAT+1.
- Idle outputs: no req in S_IDLE gives mem_addr = 0, mem_wr_data = 0, mem_wr_ena = 0.
- rdata outside rvalid: drive 0.
- Requester contract: hold req, we, addr and wdata stable until gnt.
  - A req still high in the cycle after gnt is a new request.
  - The arbiter never drops a granted access.
- conflict_count: increments by 1 in each S_IDLE cycle with m0_req & m1_req; wraps 2^32-1 -> 0.
- Reset mid-read: the pending rvalid is never issued, the FSM returns to S_IDLE, and last_owner resets to 1.
- RD_LAT outside 1..4: elaboration-time $error.

Decomposition:
- New header mem_arbiter_defines.v, holding:
  - state encodings S_ARB_IDLE / S_ARB_RD_WAIT
  - owner IDs ARB_OWNER_M0 = 0, ARB_OWNER_M1 = 1
  - RD_LAT width constant (3 bits)
- One sub-module, rr_arbiter2: combinational 2-way winner select from the two reqs, last_owner and FIXED_PRIO. No state of its own; the top block holds last_owner.

Test Plan:
1. M0 alone, write 0x0000_0010 <- 0xDEAD_BEEF: m0_gnt=1 in the same cycle and mem_wr_ena=1 for exactly 1 cycle; M0 read of 0x10 with RD_LAT=1 then returns rvalid one cycle after gnt with rdata=0xDEAD_BEEF.
2. After reset, both masters issue a read in the same cycle (M0 addr 0x0, M1 addr 0x4), RD_LAT=2: M0 granted at t with m0_rvalid at t+2; M1 granted at t+3 with m1_rvalid at t+5; conflict_count=1.
3. Both masters hold continuous write requests for 6 cycles, FIXED_PRIO=0: grants alternate M0,M1,M0,M1,M0,M1. Same stimulus with FIXED_PRIO=1: M0 gets all 6, M1 none.
4. M1 read granted with RD_LAT=3, rst pulsed low 1 cycle after gnt: m1_rvalid is never asserted, all outputs go to 0 immediately, and after release a tie grants M0.
5. In S_RD_WAIT, M0 raises a write request: m0_gnt stays 0 and mem_wr_ena stays 0 until the cycle after rvalid, then the write is granted.
6. conflict_count preloaded via force to 0xFFFF_FFFF, then one tie cycle: the counter reads 0.
